lif_hidden_layer: RTL

- Leaky integrate-and-fire hidden layer. Sits directly downstream of the input processor and consumes one INPUT_SIZE-wide rate-coded spike vector per timestep.
- Emits one HIDDEN_SIZE-wide spike vector per timestep toward the output layer.
- Integration is serialised over inputs, one input index per cycle, with all hidden neurons in parallel.
- Membranes are cleared at each SPIKE_WINDOW boundary.

---
 rtl/lif_hidden_layer_if.sv | 29 ++
 rtl/lif_hidden_layer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lif_hidden_layer_if.sv
// Spike-vector handshake, weight-write port and output spikes of the LIF hidden layer.
// master: upstream/driver side; slave: the layer itself.
interface lif_hidden_layer_if #(
  parameter int unsigned INPUT_SIZE   = 4,
  parameter int unsigned HIDDEN_SIZE  = 2,
  parameter int unsigned WEIGHT_WIDTH = 8
);
  localparam int unsigned ADDR_W = $clog2(INPUT_SIZE * HIDDEN_SIZE);

  logic                    in_valid;
  logic                    in_ready;
  logic [INPUT_SIZE-1:0]   in_spike;
  logic                    w_we;
  logic [ADDR_W-1:0]       w_addr;
  logic [WEIGHT_WIDTH-1:0] w_data;
  logic                    out_valid;
  logic [HIDDEN_SIZE-1:0]  out_spike;
  logic                    window_done;

  modport master (
    output in_valid, in_spike, w_we, w_addr, w_data,
    input  in_ready, out_valid, out_spike, window_done
  );

  modport slave (
    input  in_valid, in_spike, w_we, w_addr, w_data,
    output in_ready, out_valid, out_spike, window_done
  );
endinterface

// File: rtl/lif_hidden_layer.sv
// Leaky integrate-and-fire hidden layer: one spike vector in, one spike vector out
// per timestep. Inputs are integrated serially (one index per cycle), all neurons
// in parallel. Membranes clear at every SPIKE_WINDOW boundary.
// Optional refractory period: define LIF_REFRACTORY_EN.
package network_pkg;
  localparam int unsigned INPUT_SIZE   = 4;
  localparam int unsigned HIDDEN_SIZE  = 2;
  localparam int unsigned SPIKE_WINDOW = 16;
endpackage

module lif_hidden_layer #(
  parameter int unsigned INPUT_SIZE   = network_pkg::INPUT_SIZE,
  parameter int unsigned HIDDEN_SIZE  = network_pkg::HIDDEN_SIZE,
  parameter int unsigned SPIKE_WINDOW = network_pkg::SPIKE_WINDOW,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned MEM_WIDTH    = 16,
  parameter int          THRESHOLD    = 64,
  parameter int unsigned LEAK_SHIFT   = 3,
  parameter int unsigned REFRAC_STEPS = 2
) (
  input logic             clk,
  input logic             rst,
  lif_hidden_layer_if.slave bus
);

  localparam int unsigned W_ENTRIES = INPUT_SIZE * HIDDEN_SIZE;
  localparam int unsigned ADDR_W    = $clog2(W_ENTRIES);
  localparam int unsigned IDX_W     = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int unsigned TS_W      = (SPIKE_WINDOW > 1) ? $clog2(SPIKE_WINDOW) : 1;
  localparam int unsigned SUM_W     = MEM_WIDTH + 1;

  typedef logic signed [MEM_WIDTH-1:0]    mem_t;
  typedef logic signed [WEIGHT_WIDTH-1:0] weight_t;
  typedef logic signed [SUM_W-1:0]        sum_t;
  typedef enum logic [1:0] {IDLE, ACCUM, FIRE} state_t;

  localparam mem_t THR     = mem_t'(THRESHOLD);
  localparam mem_t MEM_MAX = mem_t'({1'b0, {(MEM_WIDTH-1){1'b1}}});
  localparam mem_t MEM_MIN = mem_t'({1'b1, {(MEM_WIDTH-1){1'b0}}});

  // A refractory period of zero steps is meaningless; reject it at elaboration.
  if (REFRAC_STEPS == 0) begin : g_refrac_steps_check
    $error("lif_hidden_layer: REFRAC_STEPS must be at least 1");
  end

  // Saturating membrane + weight add; one guard bit detects overflow.
  function automatic mem_t sat_add(mem_t a, weight_t b);
    sum_t s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s[SUM_W-1] != s[SUM_W-2]) return s[SUM_W-1] ? MEM_MIN : MEM_MAX;
    return mem_t'(s[MEM_WIDTH-1:0]);
  endfunction

  // Leaked membrane; arithmetic shift floors toward -inf for negative values.
  function automatic mem_t leak(mem_t v_in);
    return v_in - (v_in >>> LEAK_SHIFT);
  endfunction

  function automatic logic [ADDR_W-1:0] w_index(int h, logic [IDX_W-1:0] i);
    return ADDR_W'(32'(h) * INPUT_SIZE + 32'(i));
  endfunction

  state_t                 state;
  logic [INPUT_SIZE-1:0]  spike_reg;
  logic [IDX_W-1:0]       idx;
  logic [TS_W-1:0]        ts;
  mem_t                   v   [HIDDEN_SIZE];
  mem_t                   acc [HIDDEN_SIZE];
  weight_t                w   [W_ENTRIES];
  logic                   out_valid_q;
  logic                   window_done_q;
  logic [HIDDEN_SIZE-1:0] out_spike_q;
  logic [HIDDEN_SIZE-1:0] refractory_c;
  logic [HIDDEN_SIZE-1:0] fire_c;
  logic                   last_step_c;

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_spike   = out_spike_q;
  assign bus.window_done = window_done_q;
  assign last_step_c     = (ts == TS_W'(SPIKE_WINDOW - 1));

  // Per-neuron firing decision for the FIRE cycle.
  always_comb begin
    fire_c = '0;
    for (int h = 0; h < HIDDEN_SIZE; h++) begin
      fire_c[h] = !refractory_c[h] && (acc[h] >= THR);
    end
  end

`ifdef LIF_REFRACTORY_EN
  localparam int unsigned RF_W = $clog2(REFRAC_STEPS + 1);

  logic [RF_W-1:0] refr [HIDDEN_SIZE];

  // Neurons with a non-zero refractory count are held silent.
  always_comb begin
    refractory_c = '0;
    for (int h = 0; h < HIDDEN_SIZE; h++) begin
      refractory_c[h] = (refr[h] != '0);
    end
  end

  // Refractory counters: load on a spike, count down once per timestep, clear at window end.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int h = 0; h < HIDDEN_SIZE; h++) refr[h] <= '0;
    end else if (state == FIRE) begin
      for (int h = 0; h < HIDDEN_SIZE; h++) begin
        if (last_step_c)        refr[h] <= '0;
        else if (refr[h] != '0) refr[h] <= refr[h] - 1'b1;
        else if (fire_c[h])     refr[h] <= RF_W'(REFRAC_STEPS);
      end
    end
  end
`else
  assign refractory_c = '0;
`endif

  // Weight register file; writes land at the edge, so a same-cycle read sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < W_ENTRIES; k++) w[k] <= '0;
    end else if (bus.w_we && (32'(bus.w_addr) < W_ENTRIES)) begin
      w[bus.w_addr] <= weight_t'(bus.w_data);
    end
  end

  // Timestep FSM: accept and leak, serial accumulate, then fire and publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      spike_reg     <= '0;
      idx           <= '0;
      ts            <= '0;
      out_valid_q   <= 1'b0;
      out_spike_q   <= '0;
      window_done_q <= 1'b0;
      for (int h = 0; h < HIDDEN_SIZE; h++) begin
        v[h]   <= '0;
        acc[h] <= '0;
      end
    end else begin
      out_valid_q   <= 1'b0;
      window_done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            spike_reg <= bus.in_spike;
            idx       <= '0;
            for (int h = 0; h < HIDDEN_SIZE; h++) begin
              acc[h] <= refractory_c[h] ? '0 : leak(v[h]);
            end
            state <= ACCUM;
          end
        end
        ACCUM: begin
          for (int h = 0; h < HIDDEN_SIZE; h++) begin
            if (spike_reg[idx] && !refractory_c[h]) begin
              acc[h] <= sat_add(acc[h], w[w_index(h, idx)]);
            end
          end
          idx <= idx + 1'b1;
          if (idx == IDX_W'(INPUT_SIZE - 1)) state <= FIRE;
        end
        FIRE: begin
          for (int h = 0; h < HIDDEN_SIZE; h++) begin
            out_spike_q[h] <= fire_c[h];
            if (last_step_c || fire_c[h] || refractory_c[h]) v[h] <= '0;
            else                                             v[h] <= acc[h];
          end
          out_valid_q   <= 1'b1;
          window_done_q <= last_step_c;
          ts            <= last_step_c ? '0 : ts + 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
